inst_memory_prog: RTL
=====================

# inst_memory_prog

Parametrised, clocked successor to the combinational instruction memory. It stores program bytes loaded as a serial byte stream from the configuration port (I2C byte interface) with an auto-incrementing write pointer. It serves the core's instruction fetch with a registered, little-endian, multi-byte word read. It sits between the I2C slave (programming side) and the CPU fetch stage, and adds explicit program/run modes, overflow and range-error reporting, and defined read data instead of high-Z.

## Interface
Parameters:
- `PC_BITS`, 8: fetch and pointer address width.
- `BYTE_SIZE`, 8: bits per memory location.
- `DEPTH`, 32: number of byte locations. Must be ≤ 2^PC_BITS.
- `WORD_BYTES`, 4: bytes per fetched instruction. `INST_MEM_WORD` = `WORD_BYTES`*`BYTE_SIZE`.

Ports:
- `i_clk`  in  1  clock; everything is on the rising edge. One clock domain.
- `i_rst`  in  1  synchronous reset, active-high.
- `i_prog_en`  in  1  level; 1 requests PROG mode, 0 requests RUN mode.
- `i_prog_valid`  in  1  write strobe for `i_data_in`. Ignored outside PROG.
- `i_data_in`  in  BYTE_SIZE  program byte.
- `o_prog_count`  out  PC_BITS+1  bytes written since entering PROG.
- `o_prog_full`  out  1  write pointer has reached `DEPTH`.
- `o_prog_ovf`  out  1  sticky: a write was attempted while full.
- `i_fetch`  in  1  fetch request. Ignored outside RUN.
- `i_address`  in  PC_BITS  byte address of the instruction.
- `o_data_out`  out  INST_MEM_WORD  instruction word, `{mem[a+W-1],…,mem[a]}`.
- `o_data_valid`  out  1  `o_data_out` is valid this cycle.
- `o_fetch_err`  out  1  the fetch on this cycle was out of range.
- `o_busy`  out  1  1 while in PROG.

## Operation
- State machine with two states: RUN and PROG.
  - RUN→PROG when `i_prog_en`=1. On entry: write pointer ← 0, `o_prog_count` ← 0, `o_prog_ovf` ← 0.
  - PROG→RUN when `i_prog_en`=0. The pointer and count are held so the load size can be read back.
- PROG write:
  - If `i_prog_valid`=1 and pointer < `DEPTH`: `mem[ptr]` ← `i_data_in`, then ptr and count each increment by 1.
  - If `i_prog_valid`=1 and pointer = `DEPTH`: no write, the pointer does not wrap, and `o_prog_ovf` ← 1.
  - `o_prog_full` = (pointer == `DEPTH`), combinational from the registered pointer.
- RUN fetch, on `i_fetch`=1:
  - Range is OK if `i_address` + `WORD_BYTES` ≤ `DEPTH`. Compute this in PC_BITS+1 bits so there is no wrap.
  - Unaligned addresses are legal.
  - If OK: next cycle `o_data_out` = assembled word, `o_data_valid`=1, `o_fetch_err`=0.
  - If not OK: next cycle `o_data_out`=0, `o_data_valid`=1, `o_fetch_err`=1.
- If `i_fetch`=0, or the block is in PROG: next cycle `o_data_valid`=0 and `o_fetch_err`=0. `o_data_out` holds its last value.
- Memory contents are not reset. Pointer, count, flags, state and outputs are.
- `o_data_out` is never driven to Z.

## Timing
- Reset values: state=RUN, pointer=0, `o_prog_count`=0, `o_prog_full`=0 (for DEPTH>0), `o_prog_ovf`=0, `o_data_out`=0, `o_data_valid`=0, `o_fetch_err`=0, `o_busy`=0.
- Fetch latency is 1 cycle, fully pipelined: one fetch per cycle is sustained with back-to-back addresses.
- Mode change takes effect on the edge where `i_prog_en` is sampled. `o_busy` follows 1 cycle later.
- `i_prog_valid` on the same edge as RUN→PROG entry is accepted and writes `mem[0]`.
- `i_fetch` on the PROG→RUN edge is ignored. The first fetch is accepted 1 cycle after `o_busy` falls.
- Read-after-write: a byte written on edge N is visible to a fetch issued on or after edge N+2. The exact edge at which it becomes visible is tied to the mode switch rules above.
- `i_rst` asserted mid-PROG aborts the load: state→RUN and counters cleared. Bytes already written remain in memory.
- `i_rst` has priority over all other inputs on the same edge.

## Test plan
- Reset, then PROG; write bytes 0x00..0x1F (32 strobes); return to RUN. Expect `o_prog_count`=32, `o_prog_full`=1, `o_prog_ovf`=0. Fetch addr 0 → one cycle later `o_data_out`=0x03020100, valid=1.
- Unaligned fetch, addr 5 → 0x08070605. Fetch addr 28 → 0x1F1E1D1C, err=0.
- Range boundary:
  - Fetch addr 29 → data 0, err=1.
  - Fetch addr 0xFF → err=1, with no 8-bit wrap.
- With the memory full, issue a 33rd strobe of 0xAA. Expect `o_prog_ovf`=1, `mem[0]` unchanged (fetch 0 still 0x03020100), count stays 32.
- Back-to-back fetches 0, 4, 8, 12 on consecutive cycles. Expect 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive cycles.
- Assert `i_fetch` while in PROG → valid stays 0. Assert `i_rst` after 3 strobes → count=0, busy=0, and the 3 written bytes are still readable.

Source files
------------

// File: rtl/inst_memory_prog.sv
// Byte-programmable instruction memory: serial byte loading in PROG mode,
// registered little-endian multi-byte fetch with range checking in RUN mode.
module inst_memory_prog #(
    parameter int PC_BITS    = 8,
    parameter int BYTE_SIZE  = 8,
    parameter int DEPTH      = 32,
    parameter int WORD_BYTES = 4,
    localparam int INST_MEM_WORD = WORD_BYTES * BYTE_SIZE
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_prog_en,
    input  logic                     i_prog_valid,
    input  logic [BYTE_SIZE-1:0]     i_data_in,
    output logic [PC_BITS:0]         o_prog_count,
    output logic                     o_prog_full,
    output logic                     o_prog_ovf,
    input  logic                     i_fetch,
    input  logic [PC_BITS-1:0]       i_address,
    output logic [INST_MEM_WORD-1:0] o_data_out,
    output logic                     o_data_valid,
    output logic                     o_fetch_err,
    output logic                     o_busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PC_BITS:0] DEPTH_P = (PC_BITS+1)'(DEPTH);
    localparam logic [PC_BITS:0] WORD_P  = (PC_BITS+1)'(WORD_BYTES);

    typedef enum logic {RUN = 1'b0, PROG = 1'b1} state_t;

    state_t                   state;
    logic [BYTE_SIZE-1:0]     mem [DEPTH];
    logic [PC_BITS:0]         wr_ptr;
    logic [PC_BITS:0]         ptr_base;
    logic [PC_BITS:0]         fetch_end;
    logic [PC_BITS:0]         rd_idx;
    logic                     full_now;
    logic                     wr_en;
    logic                     fetch_act;
    logic                     in_range;
    logic [INST_MEM_WORD-1:0] rd_word_p0;

    // Entering PROG restarts the load at address 0, even on the entry edge itself.
    always_comb begin
        ptr_base  = (state == PROG) ? wr_ptr : '0;
        full_now  = (ptr_base == DEPTH_P);
        wr_en     = i_prog_en && i_prog_valid && !full_now;
        fetch_act = (state == RUN) && !i_prog_en && i_fetch;
        fetch_end = {1'b0, i_address} + WORD_P;
        in_range  = (fetch_end <= DEPTH_P);
    end

    always_comb begin
        rd_word_p0 = '0;
        rd_idx     = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            rd_idx = {1'b0, i_address} + (PC_BITS+1)'(i);
            rd_word_p0[i*BYTE_SIZE +: BYTE_SIZE] = mem[rd_idx[AW-1:0]];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_en) begin
            mem[ptr_base[AW-1:0]] <= i_data_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= RUN;
            wr_ptr       <= '0;
            o_prog_ovf   <= 1'b0;
            o_data_out   <= '0;
            o_data_valid <= 1'b0;
            o_fetch_err  <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state  <= i_prog_en ? PROG : RUN;
            o_busy <= i_prog_en;
            if (i_prog_en) begin
                wr_ptr <= wr_en ? ptr_base + 1'b1 : ptr_base;
                o_prog_ovf <= ((state == PROG) && o_prog_ovf) || (i_prog_valid && full_now);
            end
            // fetch stage boundary: one registered word per accepted request
            o_data_valid <= fetch_act;
            o_fetch_err  <= fetch_act && !in_range;
            if (fetch_act) begin
                o_data_out <= in_range ? rd_word_p0 : '0;
            end
        end
    end

    assign o_prog_count = wr_ptr;
    assign o_prog_full  = (wr_ptr == DEPTH_P);

endmodule
